// File: rtl/mold_pkg.sv
// rtl/mold_pkg.sv - shared widths, latency and sqrt stage record for the mold unit
package mold_pkg;

   localparam int W       = 20;
   localparam int SUM_W   = 2 * W + 2;
   localparam int ROOT_W  = SUM_W / 2;
   localparam int LATENCY = 3 + ROOT_W;

   // One stage of the digit-by-digit square root: partial remainder,
   // partial root and the radicand bits still to be consumed (MSB-aligned).
   typedef struct packed {
      logic [ROOT_W-1:0] rem;
      logic [ROOT_W-1:0] root;
      logic [SUM_W-1:0]  radicand;
   } sqrt_stage_t;

endpackage

// File: rtl/mold_if.sv
// rtl/mold_if.sv - vector input / magnitude output bundle for the mold unit
interface mold_if;
   import mold_pkg::*;

   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W-1:0] z;
   logic [W-1:0] mold;

   modport master (output x, output y, output z, input mold);
   modport slave  (input x, input y, input z, output mold);

endinterface

// File: rtl/isqrt_pipe.sv
// rtl/isqrt_pipe.sv - pipelined integer square root, one root bit per stage, MSB first
module isqrt_pipe #(
   parameter int IN_W  = 42,
   parameter int OUT_W = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  radicand,
   output logic [OUT_W-1:0] root
);

   typedef struct packed {
      logic [OUT_W-1:0] rem;
      logic [OUT_W-1:0] root;
      logic [IN_W-1:0]  radicand;
   } stage_t;

   stage_t pipe_q [OUT_W];
   stage_t pipe_d [OUT_W];
   stage_t cur;
   logic [OUT_W+1:0] rem_sh;
   logic [OUT_W+1:0] trial;

   // Each stage brings down the next two radicand bits and tries root bit = 1.
   // The remainder stays below 2^OUT_W until the final stage, whose remainder
   // is never consumed, so truncating it to OUT_W bits loses nothing.
   always_comb begin
      cur    = '0;
      rem_sh = '0;
      trial  = '0;
      for (int s = 0; s < OUT_W; s++) begin
         if (s == 0) begin
            cur          = '0;
            cur.radicand = radicand;
         end else begin
            cur = pipe_q[s-1];
         end
         rem_sh             = {cur.rem, cur.radicand[IN_W-1 -: 2]};
         trial              = {cur.root, 2'b01};
         pipe_d[s].radicand = cur.radicand << 2;
         if (rem_sh >= trial) begin
            pipe_d[s].rem  = OUT_W'(rem_sh - trial);
            pipe_d[s].root = {cur.root[OUT_W-2:0], 1'b1};
         end else begin
            pipe_d[s].rem  = OUT_W'(rem_sh);
            pipe_d[s].root = {cur.root[OUT_W-2:0], 1'b0};
         end
      end
   end

   // Stage registers; reset flushes every in-flight root.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < OUT_W; s++) pipe_q[s] <= '0;
      end else begin
         for (int s = 0; s < OUT_W; s++) pipe_q[s] <= pipe_d[s];
      end
   end

   assign root = pipe_q[OUT_W-1].root;

endmodule

// File: rtl/mold_unit.sv
// rtl/mold_unit.sv - pipelined floor(sqrt(x^2+y^2+z^2)); MOLD_SIGNED_EN selects two's-complement inputs
module mold_unit
   import mold_pkg::*;
(
   input logic  clk,
   input logic  rst_n,
   mold_if.slave io
);

   logic [W-1:0]      ax, ay, az;
   logic [2*W-1:0]    xx_q, yy_q, zz_q;
   logic [SUM_W-1:0]  s_q;
   logic [ROOT_W-1:0] r;

`ifdef MOLD_SIGNED_EN
   // Magnitude of each component; -2^(W-1) maps to 2^(W-1), still fits W bits.
   assign ax = io.x[W-1] ? (~io.x + W'(1)) : io.x;
   assign ay = io.y[W-1] ? (~io.y + W'(1)) : io.y;
   assign az = io.z[W-1] ? (~io.z + W'(1)) : io.z;
`else
   assign ax = io.x;
   assign ay = io.y;
   assign az = io.z;
`endif

   // Square stage then sum-of-squares stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xx_q <= '0;
         yy_q <= '0;
         zz_q <= '0;
         s_q  <= '0;
      end else begin
         xx_q <= (2*W)'(ax) * (2*W)'(ax);
         yy_q <= (2*W)'(ay) * (2*W)'(ay);
         zz_q <= (2*W)'(az) * (2*W)'(az);
         s_q  <= SUM_W'(xx_q) + SUM_W'(yy_q) + SUM_W'(zz_q);
      end
   end

   isqrt_pipe #(
      .IN_W  (SUM_W),
      .OUT_W (ROOT_W)
   ) u_isqrt (
      .clk      (clk),
      .rst_n    (rst_n),
      .radicand (s_q),
      .root     (r)
   );

   // Saturating output register: roots above the W-bit range clamp to all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io.mold <= '0;
      end else if (r > ROOT_W'({W{1'b1}})) begin
         io.mold <= '1;
      end else begin
         io.mold <= r[W-1:0];
      end
   end

endmodule

// File: tb/tb_mold_unit.sv
// tb/tb_mold_unit.sv - randomized and directed checks of mold_unit against a reference magnitude model
module tb_mold_unit;
   import mold_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [W-1:0] hist[$];

   mold_if io ();

   mold_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint comp_mag(input logic [W-1:0] v);
`ifdef MOLD_SIGNED_EN
      if (v[W-1]) return (longint'(1) << W) - longint'(v);
`endif
      return longint'(v);
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
      longint ma, mb, mc, s, r;
      ma = comp_mag(a);
      mb = comp_mag(b);
      mc = comp_mag(c);
      s  = ma * ma + mb * mb + mc * mc;
      r  = longint'($sqrt(real'(s)));
      while (r > 0 && r * r > s) r = r - 1;
      while ((r + 1) * (r + 1) <= s) r = r + 1;
      if (r > (longint'(1) << W) - 1) return {W{1'b1}};
      return W'(r);
   endfunction

   task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      logic [W-1:0] exp;
      io.x = a;
      io.y = b;
      io.z = c;
      @(posedge clk);
      if (rst_n) hist.push_back(model(a, b, c));
      @(negedge clk);
      exp = (hist.size() >= LATENCY) ? hist[hist.size() - LATENCY] : '0;
      checks++;
      assert (io.mold === exp) else begin
         failures++;
         $error("FAIL pipe_out got=%h exp=%h", io.mold, exp);
      end
   endtask

   task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                           input logic [W-1:0] exp, input string tag);
      step(a, b, c);
      repeat (LATENCY - 1) step('0, '0, '0);
      checks++;
      assert (io.mold === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, io.mold, exp);
      end
   endtask

   initial begin
      logic [W-1:0] a, b, c;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      io.x     = '0;
      io.y     = '0;
      io.z     = '0;
      #12;
      checks++;
      assert (io.mold === {W{1'b0}}) else begin
         failures++;
         $error("FAIL reset_state got=%h exp=0", io.mold);
      end
      @(negedge clk);
      rst_n = 1'b1;

      directed(W'(3), W'(4), W'(0), W'(5), "t1_345");
      directed(W'(1), W'(2), W'(2), W'(3), "t2_122");
      directed(W'(2), W'(3), W'(0), W'(3), "t2_floor13");
      directed('0, '0, '0, '0, "sqrt_zero");
`ifdef MOLD_SIGNED_EN
      directed(W'(20'hFFFFD), W'(4), W'(0), W'(5), "signed_m3");
      directed(W'(20'h80000), W'(0), W'(0), W'(20'h80000), "signed_min");
`else
      directed(W'(20'hFFFFF), W'(20'hFFFFF), W'(20'hFFFFF), W'(20'hFFFFF), "saturate");
      directed(W'(20'hFFFFF), W'(0), W'(0), W'(20'hFFFFF), "max_single");
`endif

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: begin a = W'($urandom); b = W'($urandom); c = W'($urandom); end
            1: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
                     c = W'($urandom_range(0, 255)); end
            2: begin a = {W{1'b1}} - W'($urandom_range(0, 15)); b = {W{1'b1}} - W'($urandom_range(0, 15));
                     c = W'($urandom); end
            default: begin a = W'($urandom); b = '0; c = W'($urandom); end
         endcase
         step(a, b, c);
      end

      for (int i = 0; i <= 1000; i++) begin
         step(W'(i), '0, '0);
         if (i == 500) begin
            #3 rst_n = 1'b0;
            #1;
            checks++;
            assert (io.mold === {W{1'b0}}) else begin
               failures++;
               $error("FAIL async_reset got=%h exp=0", io.mold);
            end
            hist.delete();
            repeat (2) step(W'(i), '0, '0);
            #3 rst_n = 1'b1;
         end
      end
      repeat (LATENCY) step('0, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
